checkpoint_seq_monitor: RTL and testbench
=========================================

CHECKPOINT_SEQ_MONITOR -- requirements
Module: checkpoint_seq_monitor

Interface
REQ-001 SHALL have parameter WIDTH, 16, checkpoint bus width in bits.
REQ-002 SHALL have parameter DEPTH, 4, maximum number of expected checkpoints.
REQ-003 SHALL have parameter TIMEOUT_W, 24, timeout counter width in bits.
REQ-004 SHALL have port wb_clk_i  in  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port check_i  in  WIDTH  asynchronous checkpoint bus, e.g. mprj_io[31:16].
REQ-007 SHALL have port start_i  in  1  one-cycle pulse that arms a run.
REQ-008 SHALL have port abort_i  in  1  one-cycle pulse that cancels a run.
REQ-009 SHALL have port strict_i  in  1  strict mode; sampled at start_i.
REQ-010 SHALL have port len_i  in  $clog2(DEPTH+1)  active entries; sampled at start_i.
REQ-011 SHALL have port limit_i  in  TIMEOUT_W  timeout in cycles; sampled at start_i.
REQ-012 SHALL have ports cfg_we_i (in, 1), cfg_addr_i (in, $clog2(DEPTH)), cfg_data_i (in, WIDTH)  expected-value table write.
REQ-013 SHALL have ports busy_o, pass_o, fail_o, hit_o (out, 1 each), fail_code_o (out, 2), stage_o (out, $clog2(DEPTH+1)).

Function
REQ-014 SHALL pass check_i through a two-flop synchronizer, then one history register; compare uses synchronized value S, history H.
REQ-015 SHALL implement states IDLE, ARMED, PASS, FAIL; busy_o = (state==ARMED), pass_o = (state==PASS), fail_o = (state==FAIL).
REQ-016 SHALL, on start_i in any state: clear stage and timeout counter, latch len/limit/strict, load H<=S, enter ARMED; if latched len==0, enter PASS instead.
REQ-017 SHALL, in ARMED with S == table[stage]: increment stage, pulse hit_o one cycle; if new stage == len, enter PASS.
REQ-018 SHALL detect one match per stage per cycle; repeated equal values (AB40 then AB40 at stage 1) SHALL not advance unless table[1] equals it.
REQ-019 SHALL, in ARMED with strict latched, S != H and S != table[stage]: enter FAIL, fail_code_o = 2'b10 (MISMATCH).
REQ-020 SHALL increment timeout counter every ARMED cycle; on reaching limit enter FAIL, fail_code_o = 2'b01 (TIMEOUT); limit==0 disables timeout.
REQ-021 SHALL give match priority over timeout and mismatch in the same cycle; start_i priority over abort_i over all else.
REQ-022 SHALL, on abort_i, enter IDLE, fail_code_o = 2'b00, stage retained.
REQ-023 SHALL hold PASS/FAIL, stage_o and fail_code_o until start_i, abort_i or reset.
REQ-024 SHALL accept table writes only when not ARMED; writes while ARMED SHALL be dropped.
REQ-025 SHALL produce hit_o exactly 3 rising edges after check_i settles on the expected value (2 sync + 1 compare).

Reset
REQ-026 SHALL, on wb_rst_i, set state IDLE, stage 0, counter 0, fail_code 00, hit_o 0, synchronizer/history flops 0, table entries 0.
REQ-027 SHALL, on reset mid-run, abandon the run with no hit_o, pass_o or fail_o pulse in the reset cycle or the one after.

Structure
REQ-028 SHALL place state enum and fail-code constants (NONE, TIMEOUT, MISMATCH) in shared package cpm_pkg.
REQ-029 SHALL instantiate sub-module cpm_sync (parametrised WIDTH two-flop synchronizer) for check_i.

Verification
REQ-030 Table {AB40,AB41,AB51}, len 3, limit 100000, non-strict; drive AB40,AB41,AB51 spaced 50 cycles -> three hit_o pulses, pass_o, stage_o=3.
REQ-031 Same table, limit 200; drive AB40 only -> fail_o with fail_code_o=01 exactly 200 ARMED cycles after start.
REQ-032 Strict, same table; drive AB40 then 1234 -> fail_o, fail_code_o=10, stage_o=1.
REQ-033 Match on the same cycle counter reaches limit -> stage advances, no FAIL; table write during ARMED -> table unchanged on readback run.
REQ-034 Assert wb_rst_i at stage 2, then restart with len 0 -> outputs at reset values, then pass_o one cycle after start_i.

Source files
------------

// File: rtl/cpm_pkg.sv
// Shared types and constants for the checkpoint sequence monitor.
package cpm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_PASS  = 2'b10,
    ST_FAIL  = 2'b11
  } cpm_state_e;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_TIMEOUT  = 2'b01;
  localparam logic [1:0] FC_MISMATCH = 2'b10;

endpackage

// File: rtl/cpm_sync.sv
// Two-flop synchronizer bringing the asynchronous checkpoint bus into the clock domain.
module cpm_sync #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Synchronizer chain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/checkpoint_seq_monitor.sv
// Watches a checkpoint bus for an ordered sequence of expected values and
// reports pass, timeout or (in strict mode) an unexpected intermediate value.
module checkpoint_seq_monitor
  import cpm_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT_W = 24
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic [WIDTH-1:0]           check_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       strict_i,
  input  logic [$clog2(DEPTH+1)-1:0] len_i,
  input  logic [TIMEOUT_W-1:0]       limit_i,
  input  logic                       cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
  input  logic [WIDTH-1:0]           cfg_data_i,
  output logic                       busy_o,
  output logic                       pass_o,
  output logic                       fail_o,
  output logic                       hit_o,
  output logic [1:0]                 fail_code_o,
  output logic [$clog2(DEPTH+1)-1:0] stage_o
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]     sync_val;
  logic [WIDTH-1:0]     hist_q;
  logic [WIDTH-1:0]     table_q [DEPTH];
  logic [WIDTH-1:0]     expected;

  cpm_state_e           state_q, state_d;
  logic [LW-1:0]        stage_q, stage_d, stage_inc;
  logic [LW-1:0]        len_q, len_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [TIMEOUT_W-1:0] limit_q, limit_d;
  logic                 strict_q, strict_d;
  logic                 hit_q, hit_d;
  logic [1:0]           code_q, code_d;

  cpm_sync #(.WIDTH(WIDTH)) u_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (check_i),
    .q_o   (sync_val)
  );

  // stage_q never reaches DEPTH while ARMED, so the truncated index is safe there
  assign expected  = table_q[stage_q[AW-1:0]];
  assign stage_inc = stage_q + LW'(1);
  assign cnt_inc   = (cnt_q == {TIMEOUT_W{1'b1}}) ? cnt_q : cnt_q + TIMEOUT_W'(1);

  // Next-state logic: start beats abort beats run evaluation; a match beats timeout and mismatch
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    limit_d  = limit_q;
    strict_d = strict_q;
    code_d   = code_q;
    hit_d    = 1'b0;
    if (start_i) begin
      stage_d  = {LW{1'b0}};
      cnt_d    = {TIMEOUT_W{1'b0}};
      len_d    = (len_i > LW'(DEPTH)) ? LW'(DEPTH) : len_i;
      limit_d  = limit_i;
      strict_d = strict_i;
      code_d   = FC_NONE;
      state_d  = (len_i == {LW{1'b0}}) ? ST_PASS : ST_ARMED;
    end else if (abort_i) begin
      state_d = ST_IDLE;
      code_d  = FC_NONE;
    end else if (state_q == ST_ARMED) begin
      cnt_d = cnt_inc;
      if (sync_val == expected) begin
        stage_d = stage_inc;
        hit_d   = 1'b1;
        if (stage_inc == len_q) begin
          state_d = ST_PASS;
        end else begin
          state_d = ST_ARMED;
        end
      end else if ((limit_q != {TIMEOUT_W{1'b0}}) && (cnt_inc >= limit_q)) begin
        state_d = ST_FAIL;
        code_d  = FC_TIMEOUT;
      end else if (strict_q && (sync_val != hist_q)) begin
        state_d = ST_FAIL;
        code_d  = FC_MISMATCH;
      end else begin
        state_d = ST_ARMED;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Run state registers; history always trails the synchronized value by one cycle
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      stage_q  <= {LW{1'b0}};
      len_q    <= {LW{1'b0}};
      cnt_q    <= {TIMEOUT_W{1'b0}};
      limit_q  <= {TIMEOUT_W{1'b0}};
      strict_q <= 1'b0;
      code_q   <= FC_NONE;
      hit_q    <= 1'b0;
      hist_q   <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      limit_q  <= limit_d;
      strict_q <= strict_d;
      code_q   <= code_d;
      hit_q    <= hit_d;
      hist_q   <= sync_val;
    end
  end

  // Expected-value table; frozen while a run is armed
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= {WIDTH{1'b0}};
      end
    end else if (cfg_we_i && (state_q != ST_ARMED)) begin
      table_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  assign busy_o      = (state_q == ST_ARMED);
  assign pass_o      = (state_q == ST_PASS);
  assign fail_o      = (state_q == ST_FAIL);
  assign hit_o       = hit_q;
  assign fail_code_o = code_q;
  assign stage_o     = stage_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Directed self-checking bench for checkpoint_seq_monitor.
module tb_checkpoint_seq_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        strict;
  logic        we;
  logic [2:0]  len;
  logic [23:0] limit;
  logic [1:0]  addr;
  logic [15:0] data;
  logic [15:0] chk;
  logic        busy, pass, fail, hit;
  logic [1:0]  code;
  logic [2:0]  stage;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  checkpoint_seq_monitor #(.WIDTH(16), .DEPTH(4), .TIMEOUT_W(24)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .check_i     (chk),
    .start_i     (start),
    .abort_i     (abort),
    .strict_i    (strict),
    .len_i       (len),
    .limit_i     (limit),
    .cfg_we_i    (we),
    .cfg_addr_i  (addr),
    .cfg_data_i  (data),
    .busy_o      (busy),
    .pass_o      (pass),
    .fail_o      (fail),
    .hit_o       (hit),
    .fail_code_o (code),
    .stage_o     (stage)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [15:0] v);
    chk = v;
    repeat (4) tick();
  endtask

  task automatic start_run(input logic [2:0] l, input logic [23:0] lim, input logic s);
    len = l; limit = lim; strict = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    we = 1'b1; addr = a; data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; strict = 1'b0; we = 1'b0;
    len = 3'd0; limit = 24'd0; addr = 2'd0; data = 16'h0000; chk = 16'h0000;
    repeat (3) tick();
    checks++;
    if ({busy, pass, fail, hit} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {busy, pass, fail, hit});
    end
    checks++;
    if ({code, stage} !== 5'b00000) begin
      failures++; $display("FAIL reset_code_stage: got code=%b stage=%0d expected 00/0", code, stage);
    end
    rst = 1'b0;
    tick();
    // table cleared by reset: entry 0 is 0000, which the idle bus already shows
    start_run(3'd1, 24'd0, 1'b0);
    tick();
    checks++;
    if ({pass, hit, stage} !== {1'b1, 1'b1, 3'd1}) begin
      failures++; $display("FAIL reset_table_zero: got pass=%b hit=%b stage=%0d expected 1/1/1", pass, hit, stage);
    end
  endtask

  task automatic test_pass();
    logic [15:0] vals [3];
    int hits;
    int bad_lat;
    vals[0] = 16'hAB40; vals[1] = 16'hAB41; vals[2] = 16'hAB51;
    hits = 0; bad_lat = 0;
    wr(2'd0, 16'hAB40); wr(2'd1, 16'hAB41); wr(2'd2, 16'hAB51);
    settle(16'h0000);
    start_run(3'd3, 24'd100000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk = vals[k];
      for (int n = 1; n <= 50; n++) begin
        tick();
        if (hit) begin
          hits++;
          if (n != 3) bad_lat++;
        end
      end
    end
    checks++;
    if (hits !== 3) begin
      failures++; $display("FAIL pass_hit_count: got %0d expected 3", hits);
    end
    checks++;
    if (bad_lat !== 0) begin
      failures++; $display("FAIL pass_hit_latency: got %0d late/early hits expected 0", bad_lat);
    end
    checks++;
    if ({pass, busy, fail, stage} !== {1'b1, 1'b0, 1'b0, 3'd3}) begin
      failures++; $display("FAIL pass_final: got pass=%b busy=%b fail=%b stage=%0d expected 1/0/0/3", pass, busy, fail, stage);
    end
  endtask

  task automatic test_timeout();
    int first_fail;
    logic busy_199;
    first_fail = 0; busy_199 = 1'b0;
    settle(16'h0000);
    start_run(3'd3, 24'd200, 1'b0);
    chk = 16'hAB40;
    for (int n = 1; n <= 260; n++) begin
      tick();
      if (n == 199) busy_199 = busy;
      if (fail && first_fail == 0) first_fail = n;
    end
    checks++;
    if (first_fail !== 200) begin
      failures++; $display("FAIL timeout_cycle: got %0d expected 200", first_fail);
    end
    checks++;
    if (busy_199 !== 1'b1) begin
      failures++; $display("FAIL timeout_busy_before: got %b expected 1", busy_199);
    end
    checks++;
    if ({code, stage} !== {2'b01, 3'd1}) begin
      failures++; $display("FAIL timeout_code_stage: got code=%b stage=%0d expected 01/1", code, stage);
    end
  endtask

  task automatic test_strict();
    settle(16'h0000);
    start_run(3'd3, 24'd0, 1'b1);
    chk = 16'hAB40;
    repeat (5) tick();
    checks++;
    if ({busy, stage} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL strict_first_hit: got busy=%b stage=%0d expected 1/1", busy, stage);
    end
    chk = 16'h1234;
    repeat (2) tick();
    checks++;
    if ({busy, fail} !== 2'b10) begin
      failures++; $display("FAIL strict_before_mismatch: got busy=%b fail=%b expected 1/0", busy, fail);
    end
    tick();
    checks++;
    if ({fail, code, stage} !== {1'b1, 2'b10, 3'd1}) begin
      failures++; $display("FAIL strict_mismatch: got fail=%b code=%b stage=%0d expected 1/10/1", fail, code, stage);
    end
  endtask

  task automatic test_match_at_limit();
    settle(16'hAB40);
    start_run(3'd3, 24'd1, 1'b0);
    tick();
    checks++;
    if ({stage, hit, fail, busy} !== {3'd1, 1'b1, 1'b0, 1'b1}) begin
      failures++; $display("FAIL match_beats_timeout: got stage=%0d hit=%b fail=%b busy=%b expected 1/1/0/1", stage, hit, fail, busy);
    end
    tick();
    checks++;
    if ({fail, code} !== {1'b1, 2'b01}) begin
      failures++; $display("FAIL timeout_after_match: got fail=%b code=%b expected 1/01", fail, code);
    end
  endtask

  task automatic test_abort_and_write();
    settle(16'h0000);
    start_run(3'd3, 24'd0, 1'b0);
    chk = 16'hAB40;
    repeat (5) tick();
    wr(2'd0, 16'hFFFF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, pass, fail, code, stage} !== {3'b000, 2'b00, 3'd1}) begin
      failures++; $display("FAIL abort_state: got busy=%b pass=%b fail=%b code=%b stage=%0d expected 0/0/0/00/1", busy, pass, fail, code, stage);
    end
    settle(16'h0000);
    start_run(3'd1, 24'd0, 1'b0);
    chk = 16'hAB40;
    repeat (3) tick();
    checks++;
    if ({hit, pass} !== 2'b11) begin
      failures++; $display("FAIL armed_write_dropped: got hit=%b pass=%b expected 1/1", hit, pass);
    end
    start = 1'b1; abort = 1'b1; len = 3'd3; limit = 24'd0; strict = 1'b0;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if ({busy, stage} !== {1'b1, 3'd0}) begin
      failures++; $display("FAIL start_beats_abort: got busy=%b stage=%0d expected 1/0", busy, stage);
    end
  endtask

  task automatic test_reset_midrun();
    settle(16'h0000);
    start_run(3'd3, 24'd0, 1'b0);
    chk = 16'hAB40;
    repeat (4) tick();
    chk = 16'hAB41;
    repeat (4) tick();
    checks++;
    if ({busy, stage} !== {1'b1, 3'd2}) begin
      failures++; $display("FAIL midrun_stage2: got busy=%b stage=%0d expected 1/2", busy, stage);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, pass, fail, hit, code, stage} !== 9'd0) begin
      failures++; $display("FAIL midrun_reset_cycle: got %b expected all zero", {busy, pass, fail, hit, code, stage});
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({busy, pass, fail, hit, code, stage} !== 9'd0) begin
      failures++; $display("FAIL midrun_after_reset: got %b expected all zero", {busy, pass, fail, hit, code, stage});
    end
    start_run(3'd0, 24'd0, 1'b0);
    checks++;
    if ({pass, busy, fail, stage} !== {1'b1, 1'b0, 1'b0, 3'd0}) begin
      failures++; $display("FAIL len0_pass: got pass=%b busy=%b fail=%b stage=%0d expected 1/0/0/0", pass, busy, fail, stage);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_timeout();
    test_strict();
    test_match_at_limit();
    test_abort_and_write();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
